// File: rtl/stack_dmem_if.sv
// Request/response and memory-side bundle for the stack data-memory front-end.
// The controller connects through the slave modport; cores and the memory model use master.
interface stack_dmem_if #(
  parameter int NCORES      = 2,
  parameter int STACK_ADDRW = 10
);
  logic [NCORES-1:0]      req_valid;
  logic [NCORES-1:0]      req_ready;
  logic [NCORES-1:0]      req_we;
  logic [32*NCORES-1:0]   req_addr;
  logic [2*NCORES-1:0]    req_size;
  logic [NCORES-1:0]      req_unsigned;
  logic [32*NCORES-1:0]   req_wdata;
  logic [NCORES-1:0]      rsp_valid;
  logic [31:0]            rsp_rdata;
  logic                   rsp_err;
  logic                   mem_re;
  logic                   mem_we;
  logic [STACK_ADDRW-1:0] mem_addr;
  logic [31:0]            mem_wdata;
  logic [3:0]             mem_wstrb;
  logic [31:0]            mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_re, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_re, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/stack_dmem_ctrl.sv
// Round-robin load/store front-end for the stack data memory: one access in flight,
// range/alignment checking, byte-lane strobes and aligned, extended load data.
module stack_dmem_ctrl #(
  parameter int          NCORES        = 2,
  parameter int          STACK_ADDRW   = 10,
  parameter int          STACK_ENTRIES = 1024,
  parameter logic [31:0] STACK_BASE    = 32'h2000_0000
) (
  input logic         clk,
  input logic         rst_n,
  stack_dmem_if.slave bus
);

  localparam int          PTRW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam logic [31:0] SPAN = 32'(4 * STACK_ENTRIES);

  typedef enum logic [1:0] {IDLE, ACCESS, READ, RESP} state_t;

  state_t          state;
  logic [PTRW-1:0] ptr;

  logic            found;
  logic [PTRW-1:0] winner;
  logic [PTRW-1:0] next_ptr;
  logic            accept;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic [1:0]      sel_size;
  logic            sel_we;
  logic            sel_uns;
  logic [31:0]     offset;
  logic            acc_err;

  logic [PTRW-1:0] grant;
  logic            lat_we;
  logic [1:0]      lat_lane;
  logic [1:0]      lat_size;
  logic            lat_uns;

  function automatic logic access_error(input logic [31:0] off, input logic [1:0] lo,
                                        input logic [1:0] size);
    access_error = (off >= SPAN) || (size == 2'b11) ||
                   (size == 2'b01 && lo[0]) || (size == 2'b10 && lo != 2'b00);
  endfunction

  function automatic logic [3:0] strobe_gen(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   strobe_gen = 4'b0001 << lo;
      2'b01:   strobe_gen = lo[1] ? 4'b1100 : 4'b0011;
      default: strobe_gen = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   wdata_rep = {4{wd[7:0]}};
      2'b01:   wdata_rep = {2{wd[15:0]}};
      default: wdata_rep = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_format(input logic [31:0] raw, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] s;
    s = raw >> {lane, 3'b000};
    case (size)
      2'b00:   load_format = uns ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      2'b01:   load_format = uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: load_format = s;
    endcase
  endfunction

  // First valid core at or after the pointer, scanning upward with wrap.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NCORES; i++) begin
      idx = (int'(ptr) + i) % NCORES;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = PTRW'(idx);
      end
    end
  end

  always_comb begin
    sel_addr  = bus.req_addr[32*winner +: 32];
    sel_wdata = bus.req_wdata[32*winner +: 32];
    sel_size  = bus.req_size[2*winner +: 2];
    sel_we    = bus.req_we[winner];
    sel_uns   = bus.req_unsigned[winner];
  end

  assign next_ptr      = (winner == PTRW'(NCORES - 1)) ? '0 : winner + PTRW'(1);
  assign accept        = rst_n && (state == IDLE) && found;
  assign bus.req_ready = accept ? (NCORES'(1) << winner) : '0;
  assign offset        = sel_addr - STACK_BASE;
  assign acc_err       = access_error(offset, sel_addr[1:0], sel_size);

  // Request fields the later states need; inputs may change after accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      grant    <= winner;
      lat_we   <= sel_we;
      lat_lane <= sel_addr[1:0];
      lat_size <= sel_size;
      lat_uns  <= sel_uns;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      bus.mem_re    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.mem_re    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            ptr <= next_ptr;
            if (acc_err) begin
              state         <= RESP;
              bus.rsp_valid <= NCORES'(1) << winner;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
            end else begin
              state         <= ACCESS;
              bus.mem_addr  <= offset[STACK_ADDRW+1:2];
              bus.mem_re    <= ~sel_we;
              bus.mem_we    <= sel_we;
              bus.mem_wstrb <= sel_we ? strobe_gen(sel_size, sel_addr[1:0]) : 4'b0000;
              if (sel_we) bus.mem_wdata <= wdata_rep(sel_size, sel_wdata);
            end
          end
        end
        ACCESS: begin
          if (lat_we) begin
            state         <= RESP;
            bus.rsp_valid <= NCORES'(1) << grant;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
          end else begin
            state <= READ;
          end
        end
        READ: begin
          state         <= RESP;
          bus.rsp_valid <= NCORES'(1) << grant;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= load_format(bus.mem_rdata, lat_lane, lat_size, lat_uns);
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stack_dmem_ctrl.md
Name: stack_dmem_ctrl

Overview:
Request front-end placed directly upstream of the stack data-memory macro. Arbitrates load/store requests from NCORES cores with round-robin, range-checks and alignment-checks byte addresses, and generates the word address, write data and byte strobes. Returns read data to the granted core, aligned and sign- or zero-extended. One access in flight at a time; no pipelining across requests.

Parameters:
NCORES, 2, number of requesting cores (1..8)
STACK_ADDRW, 10, word-address width of the memory
STACK_ENTRIES, 1024, memory depth in 32-bit words
STACK_BASE, 32'h2000_0000, byte address of word 0; must be 4-byte aligned

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
req_valid_i  in  NCORES  per-core request valid
req_ready_o  out  NCORES  per-core accept; one-hot or zero
req_we_i  in  NCORES  1=store, 0=load
req_addr_i  in  32*NCORES  byte address; core k at [32k+31:32k]
req_size_i  in  2*NCORES  00 byte, 01 half, 10 word; 11 is illegal
req_unsigned_i  in  NCORES  1=zero-extend load, 0=sign-extend load
req_wdata_i  in  32*NCORES  store data, right-justified
rsp_valid_o  out  NCORES  one-cycle response pulse to the granted core
rsp_rdata_o  out  32  formatted load data; 0 for stores and errors
rsp_err_o  out  1  qualifies rsp_valid_o: misaligned, out of range, or illegal size
mem_re_o  out  1  memory read enable
mem_we_o  out  1  memory write enable
mem_addr_o  out  STACK_ADDRW  word address
mem_wdata_o  out  32  lane-replicated store data
mem_wstrb_o  out  4  byte strobes
mem_rdata_i  in  32  memory read data, valid one cycle after mem_re_o

Behaviour:
- Reset: state IDLE; round-robin pointer = 0; all outputs 0. Reset aborts any access in progress. No response is produced for an aborted access. No mem_we_o is asserted in the cycle after reset is sampled.
- FSM: IDLE -> ACCESS -> (READ ->) RESP -> IDLE. ERR path: IDLE -> RESP.
- IDLE: the winner is the first valid core at or after the pointer, scanning upward and wrapping. req_ready_o[winner] = 1 combinationally in the same cycle. Its fields are latched. The pointer becomes winner+1 mod NCORES. With no valid request, stay in IDLE.
- Checks at accept:
  - Offset = addr - STACK_BASE, 32-bit unsigned.
  - Error if offset >= 4*STACK_ENTRIES, if size==11, if half with addr[0]=1, or if word with addr[1:0]!=0.
  - On error, go to RESP with err=1.
- ACCESS (T+1): mem_addr_o = offset[STACK_ADDRW+1:2]. Assert mem_we_o or mem_re_o for exactly this one cycle.
  - Byte store: wstrb = 1 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - Half store: wstrb = 0011 or 1100 by addr[1], wdata = {2{wdata[15:0]}}.
  - Word store: wstrb = 1111.
  - Loads: wstrb = 0.
  - Stores go to RESP; loads go to READ.
- READ (T+2): capture mem_rdata_i. Shift right by 8*addr[1:0], mask to the access size, then sign- or zero-extend per the unsigned flag.
- RESP: rsp_valid_o[granted] = 1 for one cycle with rdata/err, then IDLE.
- Latency from accept cycle T to rsp_valid_o: store T+2, load T+3, error T+1.
- New accepts are possible in the cycle after RESP (IDLE). Requests are not accepted in any non-IDLE state.
- Request inputs are not required to stay stable after accept.
- Only mem_re_o/mem_we_o are pulses; address, data and strobe outputs hold their value otherwise.

Test Plan:
- Word store 0xDEADBEEF at 0x2000_0010 by core0, then word load -> mem_addr_o=4, wstrb=1111; load rsp 0xDEADBEEF at T+3, err=0.
- Byte load at 0x2000_0013 (signed and unsigned), word holds 0x80FF_0000 -> signed 0xFFFF_FF80, unsigned 0x0000_0080.
- Half store 0x1234 at 0x2000_0002 -> wstrb=1100, wdata=0x1234_1234; other half of the word is unchanged on readback.
- Misaligned word at 0x2000_0002, and load at 0x2000_1000 (out of range) -> rsp err=1 at T+1; mem_re_o/mem_we_o never asserted.
- Both cores hold valid continuously for 6 requests -> grants alternate 0,1,0,1,0,1. Each rsp_valid_o goes only to the granted core.
- Reset asserted during ACCESS of a store -> no rsp_valid_o, all outputs 0 after the reset edge, FSM in IDLE, pointer 0.
